// File: rtl/lcd_timing_ctrl_pkg.sv
// Shared video types: LCD mode encoding, default scanline timing and the
// helper that maps a (dot, line) position onto the mode it belongs to.
package lcd_timing_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HBLANK = 2'd0,
    MODE_VBLANK = 2'd1,
    MODE_OAM    = 2'd2,
    MODE_XFER   = 2'd3
  } lcd_mode_e;

  localparam int LCD_DOTS_PER_LINE = 456;
  localparam int LCD_OAM_DOTS      = 80;
  localparam int LCD_XFER_DOTS     = 172;
  localparam int LCD_VISIBLE_LINES = 144;
  localparam int LCD_VBLANK_LINES  = 10;
  localparam int LCD_LINES         = LCD_VISIBLE_LINES + LCD_VBLANK_LINES;

  // xferEnd is the first dot of HBlank, i.e. OAM length plus transfer length.
  function automatic lcd_mode_e lcd_mode_for(input logic [8:0] dot,
                                             input logic [8:0] oamEnd,
                                             input logic [8:0] xferEnd,
                                             input logic       visible);
    lcd_mode_e m;
    if (!visible)           m = MODE_VBLANK;
    else if (dot < oamEnd)  m = MODE_OAM;
    else if (dot < xferEnd) m = MODE_XFER;
    else                    m = MODE_HBLANK;
    return m;
  endfunction

endpackage

// File: rtl/lcd_timing_ctrl_if.sv
// Control/status bundle between the CPU-facing register block and the LCD
// timing controller.
interface lcd_timing_ctrl_if;

  logic       dot_en;
  logic       lcd_enable;
  logic [7:0] lyc;
  logic [3:0] stat_ie;
  logic [7:0] ly;
  logic [1:0] mode;
  logic       coincidence;
  logic       drawline;
  logic       vblank_irq;
  logic       stat_irq;

  modport master (
    output dot_en, lcd_enable, lyc, stat_ie,
    input  ly, mode, coincidence, drawline, vblank_irq, stat_irq
  );

  modport slave (
    input  dot_en, lcd_enable, lyc, stat_ie,
    output ly, mode, coincidence, drawline, vblank_irq, stat_irq
  );

endinterface

// File: rtl/lcd_stat_irq.sv
// STAT interrupt line: OR of the enabled sources, with a rising-edge detector
// so a source hand-over while the line stays high does not re-fire.
module lcd_stat_irq
  import lcd_timing_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      active_i,
  input  lcd_mode_e mode_i,
  input  logic      coincidence_i,
  input  logic [3:0] stat_ie_i,
  output logic      stat_irq_o
);

  logic line_d;
  logic line_q;
  logic irq_q;

  // Sources are the next-state mode/coincidence so the pulse lines up with the mode change.
  always_comb begin
    line_d = active_i & ((stat_ie_i[0] & (mode_i == MODE_HBLANK)) |
                         (stat_ie_i[1] & (mode_i == MODE_VBLANK)) |
                         (stat_ie_i[2] & (mode_i == MODE_OAM))    |
                         (stat_ie_i[3] & coincidence_i));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      line_q <= line_d;
      irq_q  <= line_d & ~line_q;
    end
  end

  assign stat_irq_o = irq_q;

endmodule

// File: rtl/lcd_timing_ctrl.sv
// LCD scanline timing: dot/line counters, mode decode, coincidence and the
// drawline / VBlank / STAT pulses, all registered on the dot strobe.
module lcd_timing_ctrl
  import lcd_timing_ctrl_pkg::*;
#(
  parameter int DOTS_PER_LINE = LCD_DOTS_PER_LINE,
  parameter int OAM_DOTS      = LCD_OAM_DOTS,
  parameter int XFER_DOTS     = LCD_XFER_DOTS,
  parameter int VISIBLE_LINES = LCD_VISIBLE_LINES,
  parameter int TOTAL_LINES   = LCD_LINES
) (
  input logic         clk,
  input logic         reset,
  lcd_timing_ctrl_if.slave bus
);

  localparam logic [8:0] DOT_LAST = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] OAM_END  = 9'(OAM_DOTS);
  localparam logic [8:0] XFER_END = 9'(OAM_DOTS + XFER_DOTS);
  localparam logic [7:0] LY_VIS   = 8'(VISIBLE_LINES);
  localparam logic [7:0] LY_LAST  = 8'(TOTAL_LINES - 1);

  logic [8:0] dot_q, dot_d;
  logic [7:0] ly_q, ly_d;
  lcd_mode_e  mode_q, mode_d;
  logic       on_q, on_d;
  logic       coin_q, coin_d;
  logic       drawline_q, drawline_d;
  logic       vblank_q, vblank_d;
  logic       statIrq;

  // on_q remembers whether the display was running last edge, so a 0->1 on
  // lcd_enable spends one edge restarting the frame at line 0 in OAM.
  always_comb begin
    dot_d      = dot_q;
    ly_d       = ly_q;
    mode_d     = mode_q;
    on_d       = on_q;
    drawline_d = 1'b0;
    vblank_d   = 1'b0;
    if (!bus.lcd_enable) begin
      dot_d  = '0;
      ly_d   = '0;
      mode_d = MODE_HBLANK;
      on_d   = 1'b0;
    end else if (!on_q) begin
      dot_d  = '0;
      ly_d   = '0;
      mode_d = MODE_OAM;
      on_d   = 1'b1;
    end else if (bus.dot_en) begin
      if (dot_q == DOT_LAST) begin
        dot_d = '0;
        ly_d  = (ly_q == LY_LAST) ? 8'd0 : ly_q + 8'd1;
      end else begin
        dot_d = dot_q + 9'd1;
      end
      mode_d     = lcd_mode_for(dot_d, OAM_END, XFER_END, ly_d < LY_VIS);
      drawline_d = (mode_q == MODE_XFER) && (mode_d == MODE_HBLANK);
      vblank_d   = (ly_q == LY_VIS - 8'd1) && (ly_d == LY_VIS);
    end
    coin_d = (ly_d == bus.lyc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dot_q      <= '0;
      ly_q       <= '0;
      mode_q     <= MODE_OAM;
      on_q       <= 1'b1;
      coin_q     <= 1'b0;
      drawline_q <= 1'b0;
      vblank_q   <= 1'b0;
    end else begin
      dot_q      <= dot_d;
      ly_q       <= ly_d;
      mode_q     <= mode_d;
      on_q       <= on_d;
      coin_q     <= coin_d;
      drawline_q <= drawline_d;
      vblank_q   <= vblank_d;
    end
  end

  lcd_stat_irq u_stat_irq (
    .clk          (clk),
    .reset        (reset),
    .active_i     (bus.lcd_enable),
    .mode_i       (mode_d),
    .coincidence_i(coin_d),
    .stat_ie_i    (bus.stat_ie),
    .stat_irq_o   (statIrq)
  );

  assign bus.ly          = ly_q;
  assign bus.mode        = mode_q;
  assign bus.coincidence = coin_q;
  assign bus.drawline    = drawline_q;
  assign bus.vblank_irq  = vblank_q;
  assign bus.stat_irq    = statIrq;

endmodule
